// File: rtl/ps2_event_queue.sv
// PS/2 scancode folder plus show-ahead event FIFO: E0/F0 prefixes become {ext,release,code} events.
// Optional typematic-repeat suppression is compiled in with `define KBD_REPEAT_FILTER_EN.
module ps2_event_queue #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clock,
  input  logic                  rst,
  input  logic [7:0]            ps2_data,
  input  logic                  ps2_hit,
  input  logic                  rd,
  output logic                  ev_valid,
  output logic [7:0]            ev_code,
  output logic                  ev_ext,
  output logic                  ev_release,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow,
  input  logic                  ovf_clear,
  output logic [1:0]            dbg_state_o
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int PW    = DEPTH_LOG2 + 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } dec_state_e;

  dec_state_e state_q, state_d;

  logic       dec_push;
  logic       dec_ext;
  logic       dec_rel;
  logic [7:0] dec_code;
  logic       ev_push;

  // Decoder: state register
  always_ff @(posedge clock) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Decoder: next state, only moves on a received byte
  always_comb begin
    state_d = state_q;
    if (ps2_hit) begin
      unique case (state_q)
        ST_IDLE: begin
          if (ps2_data == 8'hE0)      state_d = ST_EXT;
          else if (ps2_data == 8'hF0) state_d = ST_BRK;
          else                        state_d = ST_IDLE;
        end
        ST_EXT: begin
          if (ps2_data == 8'hF0)      state_d = ST_EXT_BRK;
          else if (ps2_data == 8'hE0) state_d = ST_EXT;
          else                        state_d = ST_IDLE;
        end
        ST_BRK:     state_d = ST_IDLE;
        ST_EXT_BRK: state_d = ST_IDLE;
        default:    state_d = ST_IDLE;
      endcase
    end
  end

  // Decoder: event output; in the break states any byte, even a prefix value, is the code
  always_comb begin
    dec_push = 1'b0;
    dec_ext  = 1'b0;
    dec_rel  = 1'b0;
    dec_code = ps2_data;
    if (ps2_hit) begin
      unique case (state_q)
        ST_IDLE: begin
          dec_push = (ps2_data != 8'hE0) && (ps2_data != 8'hF0) &&
                     (ps2_data != 8'hE1) && (ps2_data != 8'h00) &&
                     (ps2_data != 8'hFF);
        end
        ST_EXT: begin
          dec_push = (ps2_data != 8'hF0) && (ps2_data != 8'hE0);
          dec_ext  = 1'b1;
        end
        ST_BRK: begin
          dec_push = 1'b1;
          dec_rel  = 1'b1;
        end
        ST_EXT_BRK: begin
          dec_push = 1'b1;
          dec_ext  = 1'b1;
          dec_rel  = 1'b1;
        end
        default: dec_push = 1'b0;
      endcase
    end
  end

  assign dbg_state_o = state_q;

`ifdef KBD_REPEAT_FILTER_EN
  logic       lm_valid_q;
  logic       lm_ext_q;
  logic [7:0] lm_code_q;
  logic       lm_match;
  logic       repeat_hit;

  assign lm_match   = lm_valid_q && (lm_ext_q == dec_ext) && (lm_code_q == dec_code);
  assign repeat_hit = dec_push && !dec_rel && lm_match;
  assign ev_push    = dec_push && !repeat_hit;

  // Tracks the key currently held; its release re-arms the filter
  always_ff @(posedge clock) begin
    if (rst) begin
      lm_valid_q <= 1'b0;
      lm_ext_q   <= 1'b0;
      lm_code_q  <= 8'h00;
    end else if (dec_push) begin
      if (!dec_rel && !repeat_hit) begin
        lm_valid_q <= 1'b1;
        lm_ext_q   <= dec_ext;
        lm_code_q  <= dec_code;
      end else if (dec_rel && lm_match) begin
        lm_valid_q <= 1'b0;
      end
    end
  end
`else
  assign ev_push = dec_push;
`endif

  // FIFO: extra pointer MSB separates full from empty
  logic [9:0]    mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic          overflow_q, overflow_d;
  logic          fifo_empty;
  logic          fifo_full;
  logic          do_pop;
  logic          do_push;
  logic          drop;
  logic [9:0]    head;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                      (wr_ptr_q[PW-2:0] == rd_ptr_q[PW-2:0]);
  assign do_pop     = rd && !fifo_empty;
  assign do_push    = ev_push && (!fifo_full || do_pop);
  assign drop       = ev_push && fifo_full && !do_pop;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    overflow_d = overflow_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (drop)           overflow_d = 1'b1;
    else if (ovf_clear) overflow_d = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage needs no reset: the head is masked while the queue is empty
  always_ff @(posedge clock) begin
    if (!rst && do_push) mem_q[wr_ptr_q[PW-2:0]] <= {dec_ext, dec_rel, dec_code};
  end

  assign head       = mem_q[rd_ptr_q[PW-2:0]];
  assign ev_valid   = !fifo_empty;
  assign ev_ext     = ev_valid ? head[9]   : 1'b0;
  assign ev_release = ev_valid ? head[8]   : 1'b0;
  assign ev_code    = ev_valid ? head[7:0] : 8'h00;
  assign count      = wr_ptr_q - rd_ptr_q;
  assign overflow   = overflow_q;

endmodule
